// File: rtl/lcd_bus_capture.sv
// Passive monitor for an HD44780-style LCD bus: synchronises the raw pins, decodes
// write strobes in 8-bit or 4-bit mode and queues {rs, byte} in a FWFT FIFO.
module lcd_bus_capture #(
   parameter int BUS_MODE     = 8,
   parameter int CAPTURE_EDGE = 0,
   parameter int FIFO_DEPTH   = 16,
   parameter int SYNC_STAGES  = 2,
   parameter int OVF_WIDTH    = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          lcd_rs,
   input  logic                          lcd_rw,
   input  logic                          lcd_e,
   input  logic [7:0]                    lcd_data,
   input  logic                          nibble_resync,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_rs,
   output logic [7:0]                    out_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          nibble_pending,
   output logic                          nibble_error,
   output logic [OVF_WIDTH-1:0]          overflow_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic {IDLE = 1'b0, HIGH_HELD = 1'b1} nib_state_t;

   // One chain carries all 11 pins so RS/RW/data stay aligned with E.
   logic [10:0] sync_q [SYNC_STAGES];
   logic        e_prev;
   logic        rs_sync;
   logic        rw_sync;
   logic        e_sync;
   logic [7:0]  data_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         e_prev <= 1'b0;
      end else begin
         sync_q[0] <= {lcd_rs, lcd_rw, lcd_e, lcd_data};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         e_prev <= e_sync;
      end
   end

   assign {rs_sync, rw_sync, e_sync, data_sync} = sync_q[SYNC_STAGES-1];

   logic e_edge;
   logic wr_strobe;

   assign e_edge    = (CAPTURE_EDGE != 0) ? (e_sync & ~e_prev) : (~e_sync & e_prev);
   assign wr_strobe = e_edge & ~rw_sync;

   // Nibble assembly; only advances in 4-bit mode, resync wins over a coincident strobe.
   nib_state_t state;
   logic [3:0] hi_nib;
   logic       rs_hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         nibble_pending <= 1'b0;
         nibble_error   <= 1'b0;
      end else if (BUS_MODE == 4) begin
         if (nibble_resync) begin
            state          <= IDLE;
            nibble_pending <= 1'b0;
         end else if (wr_strobe) begin
            if (state == IDLE) begin
               state          <= HIGH_HELD;
               nibble_pending <= 1'b1;
            end else begin
               state          <= IDLE;
               nibble_pending <= 1'b0;
               if (rs_sync != rs_hold) nibble_error <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_strobe && !nibble_resync && state == IDLE) begin
         hi_nib  <= data_sync[7:4];
         rs_hold <= rs_sync;
      end
   end

   logic       push_req;
   logic [8:0] push_word;

   assign push_req  = (BUS_MODE == 4) ? (wr_strobe & ~nibble_resync & (state == HIGH_HELD))
                                      : wr_strobe;
   assign push_word = (BUS_MODE == 4) ? {rs_hold, hi_nib, data_sync[7:4]}
                                      : {rs_sync, data_sync};

   // FIFO: a full queue still accepts a push when the head leaves in the same cycle.
   logic [8:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             pop;
   logic             push_ok;
   logic [8:0]       head;

   assign pop     = out_valid & out_ready;
   assign push_ok = push_req & ((fifo_level < LVL_W'(FIFO_DEPTH)) | pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_level     <= '0;
         overflow_count <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   fifo_level <= fifo_level + LVL_W'(1);
            2'b01:   fifo_level <= fifo_level - LVL_W'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (push_req && !push_ok && !(&overflow_count))
            overflow_count <= overflow_count + OVF_WIDTH'(1);
      end
   end

   assign head      = mem[rd_ptr];
   assign out_valid = (fifo_level != '0);
   assign out_rs    = out_valid & head[8];
   assign out_data  = out_valid ? head[7:0] : 8'h00;

endmodule

// File: tb/tb_lcd_bus_capture.sv
// Bench for lcd_bus_capture: one pin stream drives an 8-bit/falling-edge instance and a
// 4-bit/rising-edge instance; an event-level model predicts every output each cycle.
module tb_lcd_bus_capture;

   localparam int DEPTH = 4;
   localparam int S8    = 2;
   localparam int S4    = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       lcd_rs = 1'b0;
   logic       lcd_rw = 1'b0;
   logic       lcd_e = 1'b0;
   logic [7:0] lcd_data = 8'h00;
   logic       nibble_resync = 1'b0;
   logic       out_ready = 1'b0;

   logic       v8, rs8, pend8, err8;
   logic [7:0] d8;
   logic [2:0] lvl8;
   logic [1:0] ovf8;
   logic       v4, rs4, pend4, err4;
   logic [7:0] d4;
   logic [2:0] lvl4;
   logic [7:0] ovf4;

   always #5 clk = ~clk;

   lcd_bus_capture #(.BUS_MODE(8), .CAPTURE_EDGE(0), .FIFO_DEPTH(DEPTH),
                     .SYNC_STAGES(S8), .OVF_WIDTH(2)) u_dut8 (
      .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
      .lcd_data(lcd_data), .nibble_resync(nibble_resync), .out_valid(v8),
      .out_ready(out_ready), .out_rs(rs8), .out_data(d8), .fifo_level(lvl8),
      .nibble_pending(pend8), .nibble_error(err8), .overflow_count(ovf8));

   lcd_bus_capture #(.BUS_MODE(4), .CAPTURE_EDGE(1), .FIFO_DEPTH(DEPTH),
                     .SYNC_STAGES(S4), .OVF_WIDTH(8)) u_dut4 (
      .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
      .lcd_data(lcd_data), .nibble_resync(nibble_resync), .out_valid(v4),
      .out_ready(out_ready), .out_rs(rs4), .out_data(d4), .fifo_level(lvl4),
      .nibble_pending(pend4), .nibble_error(err4), .overflow_count(ovf4));

   typedef struct {
      int         due;
      logic       rs;
      logic       rw;
      logic [7:0] d;
   } ev_t;

   ev_t        ev8[$];
   ev_t        ev4[$];
   logic [8:0] q8[$];
   logic [8:0] q4[$];
   int         ovf8_m, ovf4_m;
   bit         pend4_m, err4_m;
   logic [3:0] hi4_m;
   logic       rs4_m;
   int         edge_n = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   bit         rand_ready = 0;
   int         ready_pct = 100;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   task automatic model_clear();
      ev8.delete(); ev4.delete(); q8.delete(); q4.delete();
      ovf8_m = 0; ovf4_m = 0; pend4_m = 0; err4_m = 0; hi4_m = '0; rs4_m = 1'b0;
   endtask

   // Applies the effect of clock edge edge_n using the inputs present at that edge.
   task automatic model_step();
      bit         pop, push, strobe;
      logic [8:0] w;
      ev_t        e;
      if (rst) begin
         model_clear();
         return;
      end
      pop = (q8.size() > 0) && out_ready; push = 0; w = '0;
      if (ev8.size() > 0 && ev8[0].due == edge_n) begin
         e = ev8.pop_front();
         if (!e.rw) begin push = 1; w = {e.rs, e.d}; end
      end
      if (pop) void'(q8.pop_front());
      if (push) begin
         if (q8.size() < DEPTH) q8.push_back(w);
         else if (ovf8_m < 3) ovf8_m++;
      end

      pop = (q4.size() > 0) && out_ready; push = 0; strobe = 0; w = '0;
      if (ev4.size() > 0 && ev4[0].due == edge_n) begin
         e = ev4.pop_front();
         strobe = !e.rw;
      end
      if (nibble_resync) pend4_m = 0;
      else if (strobe) begin
         if (!pend4_m) begin
            pend4_m = 1; hi4_m = e.d[7:4]; rs4_m = e.rs;
         end else begin
            pend4_m = 0;
            if (e.rs != rs4_m) err4_m = 1;
            push = 1; w = {rs4_m, hi4_m, e.d[7:4]};
         end
      end
      if (pop) void'(q4.pop_front());
      if (push) begin
         if (q4.size() < DEPTH) q4.push_back(w);
         else if (ovf4_m < 255) ovf4_m++;
      end
   endtask

   task automatic compare_all();
      logic [8:0] h8, h4;
      h8 = (q8.size() > 0) ? q8[0] : 9'h000;
      h4 = (q4.size() > 0) ? q4[0] : 9'h000;
      chk("valid8", v8, q8.size() != 0);
      chk("rs8", rs8, h8[8]);
      chk("data8", d8, h8[7:0]);
      chk("level8", lvl8, q8.size());
      chk("pend8", pend8, 0);
      chk("err8", err8, 0);
      chk("ovf8", ovf8, ovf8_m);
      chk("valid4", v4, q4.size() != 0);
      chk("rs4", rs4, h4[8]);
      chk("data4", d4, h4[7:0]);
      chk("level4", lvl4, q4.size());
      chk("pend4", pend4, pend4_m);
      chk("err4", err4, err4_m);
      chk("ovf4", ovf4, ovf4_m);
   endtask

   task automatic tick();
      @(posedge clk);
      edge_n++;
      #1;
      model_step();
      compare_all();
      if (rand_ready) out_ready = ($urandom_range(0, 99) < ready_pct);
   endtask

   // Records the capturing edge for whichever instance sees it; it is first sampled next edge.
   task automatic drive(input logic rs, input logic rw, input logic e, input logic [7:0] d);
      ev_t ev;
      ev.rs = rs; ev.rw = rw; ev.d = d; ev.due = 0;
      if (e && !lcd_e) begin ev.due = edge_n + 1 + S4; ev4.push_back(ev); end
      if (!e && lcd_e) begin ev.due = edge_n + 1 + S8; ev8.push_back(ev); end
      lcd_rs = rs; lcd_rw = rw; lcd_e = e; lcd_data = d;
   endtask

   task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, input int gap);
      drive(rs, rw, 1'b0, d); repeat (2 + gap) tick();
      drive(rs, rw, 1'b1, d); repeat (2) tick();
      drive(rs, rw, 1'b0, d); repeat (2) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_clear();
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic resync_pulse();
      nibble_resync = 1'b1;
      tick();
      nibble_resync = 1'b0;
   endtask

   initial begin
      int due;
      model_clear();
      #1;
      chk("rst_valid8", v8, 0);
      chk("rst_level8", lvl8, 0);
      chk("rst_data4", d4, 0);
      chk("rst_pend4", pend4, 0);
      chk("rst_err4", err4, 0);
      chk("rst_ovf4", ovf4, 0);
      do_reset();

      // 8-bit bytes with a ready consumer
      out_ready = 1'b1;
      xfer(1'b0, 1'b0, 8'h38, 0);
      xfer(1'b1, 1'b0, 8'h41, 0);
      repeat (4) tick();

      // 4-bit nibble pairs, consumer stalled
      do_reset();
      out_ready = 1'b0;
      xfer(1'b1, 1'b0, 8'h40, 0);
      chk("nib_pending_mid", pend4, 1);
      xfer(1'b1, 1'b0, 8'h10, 0);
      xfer(1'b0, 1'b0, 8'h20, 0);
      xfer(1'b1, 1'b0, 8'h80, 0);
      repeat (4) tick();
      chk("nib_level", lvl4, 2);
      chk("nib_head", d4, 8'h41);
      chk("nib_head_rs", rs4, 1);
      chk("nib_error", err4, 1);
      chk("byte_level_full", lvl8, 4);

      // reads ignored; resync drops a held high nibble
      do_reset();
      xfer(1'b0, 1'b1, 8'hAA, 0);
      xfer(1'b0, 1'b0, 8'h50, 0);
      chk("resync_pend_before", pend4, 1);
      resync_pulse();
      xfer(1'b0, 1'b0, 8'h30, 0);
      xfer(1'b0, 1'b0, 8'h00, 0);
      repeat (4) tick();
      chk("resync_level", lvl4, 1);
      chk("resync_head", d4, 8'h30);
      chk("read_skip_level8", lvl8, 3);
      chk("read_skip_head8", d8, 8'h50);

      // overflow and saturation on the 2-bit counter
      do_reset();
      for (int i = 1; i <= 6; i++) xfer(1'b0, 1'b0, 8'(i * 8'h11), 0);
      repeat (3) tick();
      chk("ovf_level", lvl8, 4);
      chk("ovf_count", ovf8, 2);
      chk("ovf_head", d8, 8'h11);
      for (int i = 7; i <= 9; i++) xfer(1'b0, 1'b0, 8'(i * 8'h11), 0);
      repeat (3) tick();
      chk("ovf_saturate", ovf8, 3);

      // full FIFO: push and pop on the same edge
      drive(1'b0, 1'b0, 1'b0, 8'hA5); repeat (2) tick();
      drive(1'b0, 1'b0, 1'b1, 8'hA5); repeat (2) tick();
      drive(1'b0, 1'b0, 1'b0, 8'hA5);
      due = edge_n + 1 + S8;
      while (edge_n < due - 1) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("full_pushpop_level", lvl8, 4);
      chk("full_pushpop_head", d8, 8'h22);
      out_ready = 1'b1;
      repeat (6) tick();

      // reset between nibbles, then a clean byte
      out_ready = 1'b0;
      xfer(1'b1, 1'b0, 8'h70, 0);
      chk("mid_pend", pend4, 1);
      do_reset();
      chk("mid_rst_level4", lvl4, 0);
      chk("mid_rst_pend4", pend4, 0);
      chk("mid_rst_level8", lvl8, 0);
      xfer(1'b1, 1'b0, 8'h40, 0);
      xfer(1'b1, 1'b0, 8'h20, 0);
      repeat (4) tick();
      chk("post_rst_byte", d4, 8'h42);

      // randomized traffic
      rand_ready = 1;
      for (int i = 0; i < 220; i++) begin
         if (i % 20 == 0) begin
            case ($urandom_range(0, 3))
               0:       ready_pct = 0;
               1:       ready_pct = 30;
               2:       ready_pct = 70;
               default: ready_pct = 100;
            endcase
         end
         if ($urandom_range(0, 99) < 8) resync_pulse();
         if ($urandom_range(0, 99) < 2) do_reset();
         xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
              8'($urandom_range(0, 255)), $urandom_range(0, 3));
      end
      rand_ready = 0;
      out_ready = 1'b1;
      repeat (10) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lcd_bus_capture.md
# lcd_bus_capture

Synthesizable capture block for the HD44780-style LCD bus driven by the Niski core. It oversamples the raw `lcd_rs`/`lcd_rw`/`lcd_e`/`lcd_data` pins in the system clock domain, decodes write strobes in 8-bit or 4-bit bus mode, and queues each completed `{rs, byte}` transfer in a FIFO. Consumers (a debug UART bridge, or an on-chip checker in simulation) drain the FIFO through a valid/ready port. It replaces ad-hoc `$display` monitoring of the LCD bus with a reusable, parametrised, hardware-visible monitor.

## Interface
Parameters:
- `BUS_MODE`, 8: bus width decoded; 8 or 4. In 4-bit mode only `lcd_data[7:4]` is used.
- `CAPTURE_EDGE`, 0: 0 latches on the falling edge of E (HD44780 behaviour); 1 latches on the rising edge.
- `FIFO_DEPTH`, 16: number of entries; power of two, ≥ 2.
- `SYNC_STAGES`, 2: synchroniser flops per input pin; ≥ 2.
- `OVF_WIDTH`, 8: width of the dropped-transfer counter.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `lcd_rs`, `lcd_rw`, `lcd_e` in 1: raw, asynchronous LCD control pins.
- `lcd_data` in 8: raw, asynchronous LCD data pins.
- `nibble_resync` in 1: synchronous pulse; discards any pending high nibble.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer accepts the head.
- `out_rs` out 1: RS of the head entry.
- `out_data` out 8: byte of the head entry.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `nibble_pending` out 1: 4-bit mode, high nibble held and awaiting low nibble.
- `nibble_error` out 1: sticky; RS changed between the two nibbles of one byte.
- `overflow_count` out OVF_WIDTH: transfers dropped because the FIFO was full; saturates.

## Operation
- All 11 pin inputs pass through identical `SYNC_STAGES` chains, so RS, RW and data stay aligned with E. An extra register holds the previous synchronised E.
- Strobe: `e_sync & ~e_prev` when `CAPTURE_EDGE=1`; `~e_sync & e_prev` when 0. A strobe with synchronised `rw=1` (a read) is ignored entirely.
- 8-bit mode: each write strobe produces a push of `{rs, data[7:0]}`.
- 4-bit mode uses a two-state FSM:
  - IDLE → HIGH_HELD on a write strobe. Store `data[7:4]` and RS, set `nibble_pending`.
  - HIGH_HELD → IDLE on the next write strobe. Push `{rs_stored, hi, data[7:4]}`.
  - If the current RS differs from `rs_stored`, set `nibble_error`. The byte is still pushed with `rs_stored`.
  - `nibble_resync` forces IDLE and has priority over a coincident strobe, which is consumed and discarded.
- FIFO is first-word-fall-through: `out_rs`/`out_data` reflect the head whenever `out_valid=1`, and are 0 when empty.
- Pop occurs when `out_valid & out_ready`.
- A push is accepted if `fifo_level < FIFO_DEPTH`, or if a pop occurs in the same cycle. Otherwise it is dropped and `overflow_count` increments, holding at all-ones.
- Push and pop in the same cycle on an empty FIFO: the pop is not possible (`out_valid=0`), the push is accepted, and the level becomes 1.
- Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap modulo the depth.
- `nibble_error` and `overflow_count` clear only on `rst`.

## Timing
- Reset values: `out_valid=0`, `out_rs=0`, `out_data=0`, `fifo_level=0`, `nibble_pending=0`, `nibble_error=0`, `overflow_count=0`. Synchronisers reset to 0, FSM resets to IDLE.
- Latency: the capturing edge of E is first sampled at clock edge t. The push happens at edge t+SYNC_STAGES, and `out_valid` is high after that edge.
- Pin requirements:
  - E high ≥ 2 clk and E low ≥ 2 clk.
  - RS/RW/data stable from 2 clk before the capturing E edge until 2 clk after it.
  - Shorter pulses may be missed; there is no other requirement.
- Throughput: one push per clock maximum, and one pop per clock.
- `fifo_level` updates on the clock edge that performs the push or pop.
- `rst` asserted mid-transfer clears the FIFO contents, the FSM and all counters immediately. The first strobe after reset release is decoded normally.

## Test plan
- **8-bit mode, CAPTURE_EDGE=0:** write 0x38 with RS=0, then 0x41 with RS=1, with `out_ready=1`. Expect heads {0,0x38} then {1,0x41}, each appearing SYNC_STAGES clk after E falls.
- **4-bit mode:** nibbles 0x4 then 0x1, RS=1. Expect one entry {1,0x41} and `nibble_pending` high between the two strobes. Then 0x2 (RS=0) followed by 0x8 (RS=1): expect entry {0,0x28} and `nibble_error=1`.
- **Reads and resync:** a read strobe (RW=1) produces no entry. In 4-bit mode, send a high nibble, pulse `nibble_resync`, then send 0x3, 0x0: expect a single entry 0x30.
- **Overflow, FIFO_DEPTH=4, `out_ready=0`:** 6 writes → `fifo_level=4`, `overflow_count=2`, and the head is the first byte. Then drain: expect the first 4 bytes in order.
- **Boundaries:** with the FIFO full, a push and pop in the same cycle is accepted with the level staying 4. With OVF_WIDTH=2, 5 drops hold `overflow_count` at 3. Asserting `rst` between nibbles yields level 0 and pending 0.
